// File: rtl/ringosc_freq_meter.sv
// Purpose : ring-oscillator frequency meter; counts synchronized rising edges of osc_in over a window of clk cycles.
// Latency : osc_in edge reaches the counter 3 clk cycles after it arrives; the result appears SETTLE+N+1 cycles after start.
// Backpressure: none; start is a level request taken only in IDLE, and the result is held until the next done.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start           measurement request (sampled in IDLE only)
//   gate_cycles     window length in clk cycles, 0 encodes 2^GATE_W; latched at acceptance
//   osc_in          ring oscillator output, asynchronous to clk
//   osc_en          oscillator enable
//   busy            measurement in progress
//   done            one-cycle result strobe
//   count/overflow  saturating edge count of the last window and its saturation flag
//
// Build option: define RINGOSC_FM_CONTINUOUS_EN to keep measuring back-to-back
// windows while start stays high (no re-warm-up between windows).
module ringosc_freq_meter #(
    parameter int GATE_W = 8,
    parameter int CNT_W  = 8,
    parameter int SETTLE = 4     // must be >= 3 so the synchronizer and history flops are flushed
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              osc_in,
    output logic              osc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int SETTLE_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    // One down-counter serves both the warm-up and the gate window.
    localparam int TMR_W    = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]        state;
    logic [GATE_W-1:0] gate_lat;
    logic [TMR_W-1:0]  tmr;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_ovf;

    logic              sync1;
    logic              sync2;
    logic              hist;
    logic              edge_det;

    logic [GATE_W-1:0] gate_m1;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;

`ifdef RINGOSC_FM_CONTINUOUS_EN
    // Cleared as soon as start drops, so the run ends after the current window
    // even if start comes back before that window's done.
    logic              run;
`endif

    // ------------------------------------------------------------------
    // osc_in synchronizer plus history flop for rising-edge detection.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= osc_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_det = sync2 & ~hist;

    // Window length minus one; wraps 0 -> all-ones, which gives the 2^GATE_W window.
    assign gate_m1 = gate_lat - 1'b1;

    // Saturating increment; an edge seen at full scale only raises the overflow flag.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = cnt_ovf;
        if (edge_det) begin
            if (&cnt) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gate_lat <= '0;
            tmr      <= '0;
            cnt      <= '0;
            cnt_ovf  <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
`ifdef RINGOSC_FM_CONTINUOUS_EN
            run      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef RINGOSC_FM_CONTINUOUS_EN
            if (state != ST_IDLE && !start) begin
                run <= 1'b0;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        gate_lat <= gate_cycles;
                        tmr      <= TMR_W'(SETTLE - 1);
                        cnt      <= '0;
                        cnt_ovf  <= 1'b0;
                        state    <= ST_WARMUP;
`ifdef RINGOSC_FM_CONTINUOUS_EN
                        run      <= 1'b1;
`endif
                    end
                end

                ST_WARMUP: begin
                    if (tmr == '0) begin
                        tmr   <= TMR_W'(gate_m1);
                        state <= ST_GATE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                ST_GATE: begin
                    cnt     <= cnt_nxt;
                    cnt_ovf <= ovf_nxt;
                    if (tmr == '0) begin
                        // Publish including an edge detected on this final window cycle.
                        count    <= cnt_nxt;
                        overflow <= ovf_nxt;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                default: begin // ST_DONE
                    state <= ST_IDLE;
`ifdef RINGOSC_FM_CONTINUOUS_EN
                    if (run && start) begin
                        tmr     <= TMR_W'(gate_m1);
                        cnt     <= '0;
                        cnt_ovf <= 1'b0;
                        state   <= ST_GATE;
                    end
`endif
                end
            endcase
        end
    end

    // Decoded from the state register so reset drops them without waiting for a clock.
    assign busy = (state != ST_IDLE);

`ifdef RINGOSC_FM_CONTINUOUS_EN
    assign osc_en = (state != ST_IDLE);
`else
    assign osc_en = (state == ST_WARMUP) || (state == ST_GATE);
`endif

endmodule

// File: tb/tb_ringosc_freq_meter.sv
module tb_ringosc_freq_meter;

    localparam int GATE_W  = 8;
    localparam int CNT_W   = 4;
    localparam int SETTLE  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HIST_N  = 32768;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [GATE_W-1:0] gate_cycles;
    logic              osc_in;
    logic              osc_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    always #5 clk = ~clk;

    ringosc_freq_meter #(
        .GATE_W (GATE_W),
        .CNT_W  (CNT_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .gate_cycles (gate_cycles),
        .osc_in      (osc_in),
        .osc_en      (osc_en),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (overflow)
    );

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit samp [0:HIST_N-1];

    // Oscillator model: 0 = fixed half period, 1 = random half periods, 2 = stuck low.
    int osc_mode = 0;
    int half     = 4;
    int cur_half = 4;
    int ph       = 0;

    // Record the osc_in value present at every rising clk edge; cyc is the edge index.
    always @(posedge clk) begin
        if (cyc < HIST_N) samp[cyc] = osc_in;
        cyc++;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (osc_en !== 1'b1 || osc_mode == 2) begin
            osc_in   = 1'b0;
            ph       = 0;
            cur_half = (osc_mode == 1) ? int'($urandom_range(1, 4)) : half;
        end else begin
            ph++;
            if (ph >= cur_half) begin
                osc_in   = ~osc_in;
                ph       = 0;
                cur_half = (osc_mode == 1) ? int'($urandom_range(1, 4)) : half;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising edges of osc_in that a window accepted at edge k with length n must count.
    // The window counts at edges k+SETTLE+1 .. k+SETTLE+n; two synchronizer stages
    // mean an edge first sampled at clk edge c is counted at edge c+2.
    function automatic int ref_edges(input int k, input int n);
        int e = 0;
        for (int c = k + SETTLE - 1; c <= k + SETTLE + n - 2; c++) begin
            if (c >= 1 && c < HIST_N && samp[c] && !samp[c-1]) e++;
        end
        return e;
    endfunction

    function automatic int win_len(input int g);
        return (g == 0) ? (1 << GATE_W) : g;
    endfunction

    task automatic wait_done(output int e, output bit ok);
        ok = 1'b0;
        e  = -1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (done === 1'b1) begin
                ok = 1'b1;
                e  = cyc - 1;
            end
        end
    endtask

    // Accept a measurement (called #1 after a clk edge); returns the acceptance edge.
    task automatic do_start(input int g, output int k);
        gate_cycles = GATE_W'(g);
        start       = 1'b1;
        tick();
        k     = cyc - 1;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int k, input int n);
        int raw;
        raw = ref_edges(k, n);
        chk({tag, "_count"}, 32'(count), (raw > CNT_MAX) ? CNT_MAX : raw);
        chk({tag, "_ovf"}, 32'(overflow), 32'(raw > CNT_MAX));
    endtask

    task automatic run_and_check(input string tag, input int g);
        int k;
        int e;
        bit ok;
        do_start(g, k);
        chk({tag, "_busy_on"}, 32'(busy), 1);
        chk({tag, "_osc_en_on"}, 32'(osc_en), 1);
        gate_cycles = GATE_W'($urandom);   // must not affect the running window
        wait_done(e, ok);
        chk({tag, "_done_seen"}, 32'(ok), 1);
        chk({tag, "_done_edge"}, e, k + SETTLE + win_len(g));
        check_result(tag, k, win_len(g));
        chk({tag, "_osc_en_done"}, 32'(osc_en), 0);
        tick();
        chk({tag, "_done_low"}, 32'(done), 0);
        chk({tag, "_busy_off"}, 32'(busy), 0);
    endtask

    initial begin
        int k;
        int e;
        int e1;
        int d0;
        bit ok;

        rst         = 1'b1;
        start       = 1'b0;
        gate_cycles = '0;
        osc_in      = 1'b0;
        repeat (3) tick();
        chk("rst_osc_en", 32'(osc_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Period 8, window 64: about 8 edges.
        osc_mode = 0;
        half     = 4;
        run_and_check("p8_g64", 64);
        chk("p8_g64_range", 32'(count >= 7 && count <= 9), 1);

        // Period 4, window 256 with CNT_W=4: saturates.
        half = 2;
        run_and_check("sat", 0);
        chk("sat_count_max", 32'(count), CNT_MAX);
        chk("sat_ovf_set", 32'(overflow), 1);

        // Oscillator stuck low.
        osc_mode = 2;
        d0 = done_cnt;
        run_and_check("quiet", 10);
        repeat (3) tick();
        chk("quiet_done_once", done_cnt - d0, 1);
        chk("quiet_count_zero", 32'(count), 0);

        // start pulsed during GATE and during DONE is ignored.
        osc_mode = 1;
        d0 = done_cnt;
        do_start(20, k);
        repeat (SETTLE + 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(e, ok);
        chk("ign_done_seen", 32'(ok), 1);
        chk("ign_done_edge", e, k + SETTLE + 20);
        check_result("ign", k, 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy_after_done", 32'(busy), 0);
        repeat (5) tick();
        chk("ign_done_once", done_cnt - d0, 1);
        chk("ign_still_idle", 32'(busy), 0);
        run_and_check("fresh", 12);

        // Asynchronous reset in the middle of a window.
        do_start(40, k);
        repeat (SETTLE + 10) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_osc_en", 32'(osc_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_ovf", 32'(overflow), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle_busy", 32'(busy), 0);
        chk("arst_idle_osc_en", 32'(osc_en), 0);
        run_and_check("post_rst", 30);

        // Back-to-back with start held; the window change applies only to the next acceptance.
        osc_mode = 0;
        half     = 3;
        gate_cycles = GATE_W'(16);
        start = 1'b1;
        tick();
        k = cyc - 1;
        gate_cycles = GATE_W'(5);
        wait_done(e1, ok);
        chk("b2b_done1_seen", 32'(ok), 1);
        chk("b2b_done1_edge", e1, k + SETTLE + 16);
        check_result("b2b1", k, 16);
        wait_done(e, ok);
        start = 1'b0;
        chk("b2b_done2_seen", 32'(ok), 1);
        chk("b2b_period", e - e1, SETTLE + 5 + 2);
        check_result("b2b2", e1 + 2, 5);
        repeat (3) tick();

        // Randomized windows and oscillator waveforms.
        for (int i = 0; i < 8; i++) begin
            osc_mode = int'($urandom_range(0, 1));
            half     = int'($urandom_range(1, 5));
            run_and_check($sformatf("rnd%0d", i), int'($urandom_range(1, 80)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
